mtimer: RTL
===========

# mtimer

Machine-timer block consuming a free-running prescaled tick and producing the RISC-V `mtime`/`mtimecmp` pair plus the machine timer interrupt. It sits downstream of the core's cycle-count logic and feeds `irq_o` to the interrupt/CSR stage. It also exposes a 32-bit register port for the load/store unit.

## Interface
- `PRESCALE_W`, default 8: width of the prescaler divisor input and internal prescale counter.

- `clk_i` input 1: clock, all state on rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `enable_i` input 1: timer run enable; low freezes prescaler and `mtime`.
- `prescale_i` input PRESCALE_W: tick period minus one (0 = tick every enabled cycle).
- `wr_en_i` input 1: register write strobe, single cycle.
- `wr_addr_i` input 2: 0 `mtime[31:0]`, 1 `mtime[63:32]`, 2 `mtimecmp[31:0]`, 3 `mtimecmp[63:32]`.
- `wr_data_i` input 32: write data.
- `rd_addr_i` input 2: read select, same map.
- `rd_data_o` output 32: registered read data.
- `tick_o` output 1: one-cycle pulse on each `mtime` increment.
- `mtime_o` output 64: current `mtime` register.
- `irq_o` output 1: registered `mtime >= mtimecmp`.

## Operation
- Reset values: prescale counter 0, `mtime` 0, `mtimecmp` 64'hFFFF_FFFF_FFFF_FFFF, `irq_o` 0, `tick_o` 0, `rd_data_o` 0.
- Prescaler: when `enable_i`=1, the counter increments each cycle.
  - When counter >= `prescale_i`, the counter loads 0 and a tick occurs. The comparison is `>=` so a lowered `prescale_i` never strands the counter.
  - When `enable_i`=0, the counter holds and no tick occurs.
- Tick: `mtime` <= `mtime` + 1, a 64-bit unsigned increment that wraps from all-ones to 0. `tick_o` is asserted in the cycle after the tick edge, aligned with the new `mtime_o` value.
- Writes update only the addressed 32-bit half; the other half is unchanged. There are no carries between halves on writes.
- Write to `mtime` (either half) in the same cycle as a tick: the write wins. The written half takes `wr_data_i`, the other half keeps its pre-increment value, no increment is applied, and `tick_o` still pulses.
- `irq_o` is level, never latched: cleared by raising `mtimecmp` or writing `mtime` below it.
- `rd_data_o` returns the addressed half one cycle after `rd_addr_i` is presented. Read-during-write returns the pre-write value.
- `rst_i` overrides everything, including a concurrent `wr_en_i`.

## Timing
- Prescaler period: one tick every `prescale_i`+1 enabled cycles.
- Latency from the tick edge to `mtime_o` updated: 0 cycles (register output). `tick_o` is high in that same cycle.
- `irq_o` lags register state by one cycle: `irq_o`(n+1) = (`mtime`(n) >= `mtimecmp`(n)).
- A write to `mtimecmp` at edge n affects `irq_o` at edge n+1.
- Read latency: 1 cycle. Write latency: visible on `mtime_o` / internal state at the next edge.
- Reset mid-count: the next edge after `rst_i` high restores all reset values. Counting resumes with the first enabled cycle after `rst_i` falls, and the first tick comes after `prescale_i`+1 enabled cycles.

## Configuration
- `MTIMER_PRESCALER_EN` defined: the prescaler behaves as above.
- `MTIMER_PRESCALER_EN` undefined:
  - The prescale counter is removed and `prescale_i` is ignored.
  - Every cycle with `enable_i`=1 is a tick, and `tick_o` is the registered `enable_i`.
  - All other behaviour is identical.

## Test plan
- Reset, `prescale_i`=3, `enable_i`=1 for 16 cycles:
  - `mtime_o` = 4, with `tick_o` pulsing every 4th cycle.
  - `irq_o`=0 throughout (cmp is all-ones).
- Write cmp lo=10 and cmp hi=0, `prescale_i`=0, enable:
  - `irq_o` rises exactly one cycle after `mtime_o` reaches 10.
  - Writing cmp lo=100 drops `irq_o` one cycle later.
- Write `mtime` lo=32'hFFFF_FFFF and hi=0, then one tick: `mtime_o` = 64'h1_0000_0000. Full wrap: `mtime`=all-ones plus one tick gives 0.
- Write `mtime` lo=5 on a tick cycle with `mtime`=20 and `prescale_i`=0:
  - Next `mtime_o` = 5, not 21 or 6.
  - `tick_o` pulses.
- `prescale_i`=7, counter at 6, change `prescale_i` to 2: a tick occurs on the next enabled cycle, then every 3 cycles.
- Assert `rst_i` together with `wr_en_i` to `mtime` lo=55 while running:
  - Next cycle `mtime_o`=0, `irq_o`=0, `rd_data_o`=0.
  - Read of addr 3 after reset returns 32'hFFFF_FFFF.

Source files
------------

// File: rtl/mtimer_if.sv
// Register port between the load/store unit and the machine timer.
// The master drives writes and the read select; the slave returns registered read data.
interface mtimer_if;
  logic        wr_en_i;
  logic [1:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic [1:0]  rd_addr_i;
  logic [31:0] rd_data_o;

  // No handshake: a write is a single-cycle strobe and is always accepted;
  // a read select presented in cycle n returns its data in cycle n+1.
  modport master (
    output wr_en_i,
    output wr_addr_i,
    output wr_data_i,
    output rd_addr_i,
    input  rd_data_o
  );

  modport slave (
    input  wr_en_i,
    input  wr_addr_i,
    input  wr_data_i,
    input  rd_addr_i,
    output rd_data_o
  );
endinterface

// File: rtl/mtimer.sv
// RISC-V machine timer: mtime/mtimecmp pair, tick pulse and level timer interrupt.
// Define MTIMER_PRESCALER_EN to enable the prescaler; otherwise every enabled cycle is a tick.
module mtimer #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  mtimer_if.slave               bus,
  output logic                  tick_o,
  output logic [63:0]           mtime_o,
  output logic                  irq_o
);

  logic        tick;
  logic        tick_q;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        irq_q, irq_d;
  logic [31:0] rd_data_q, rd_data_d;

`ifdef MTIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // Compare with >= so lowering prescale_i below the current count still ticks.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (enable_i) begin
      if (cnt_q >= prescale_i) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale_i;
  assign tick            = enable_i;
`endif

  logic wr_time_lo, wr_time_hi, wr_cmp_lo, wr_cmp_hi;
  assign wr_time_lo = bus.wr_en_i && (bus.wr_addr_i == 2'd0);
  assign wr_time_hi = bus.wr_en_i && (bus.wr_addr_i == 2'd1);
  assign wr_cmp_lo  = bus.wr_en_i && (bus.wr_addr_i == 2'd2);
  assign wr_cmp_hi  = bus.wr_en_i && (bus.wr_addr_i == 2'd3);

  // A write to either mtime half overrides a concurrent increment entirely.
  always_comb begin
    mtime_d = mtime_q;
    if (tick) mtime_d = mtime_q + 64'd1;
    if (wr_time_lo)      mtime_d = {mtime_q[63:32], bus.wr_data_i};
    else if (wr_time_hi) mtime_d = {bus.wr_data_i, mtime_q[31:0]};
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr_cmp_lo)      mtimecmp_d = {mtimecmp_q[63:32], bus.wr_data_i};
    else if (wr_cmp_hi) mtimecmp_d = {bus.wr_data_i, mtimecmp_q[31:0]};
  end

  always_comb begin
    irq_d = (mtime_q >= mtimecmp_q);
    case (bus.rd_addr_i)
      2'd0:    rd_data_d = mtime_q[31:0];
      2'd1:    rd_data_d = mtime_q[63:32];
      2'd2:    rd_data_d = mtimecmp_q[31:0];
      default: rd_data_d = mtimecmp_q[63:32];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
      tick_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= irq_d;
      tick_q     <= tick;
      rd_data_q  <= rd_data_d;
    end
  end

  assign mtime_o       = mtime_q;
  assign tick_o        = tick_q;
  assign irq_o         = irq_q;
  assign bus.rd_data_o = rd_data_q;

endmodule
